nn_batch_sequencer: RTL and testbench

//  Sequences NN inference over a batch of images stored back-to-back in SRAM. Drives the NN start/done handshake.

---
 rtl/nn_batch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_nn_batch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_batch_sequencer.sv
// Batch sequencer for NN inference over images stored back-to-back in SRAM.
// Drives the NN start/done handshake, offsets SRAM addresses and keeps results.
module nn_batch_sequencer #(
  parameter int          NUM_IMAGES = 4,
  parameter int          IMG_WORDS  = 392,
  parameter logic [19:0] BASE_ADDR  = 20'h0,
  parameter int          LADDR_W    = 16,
  parameter int          PRED_W     = 4,
  parameter int          DEBOUNCE   = 16,
  localparam int         IDX_W      = $clog2(NUM_IMAGES) + 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               STEP_N,
  input  logic               AUTO,
  output logic               NN_START,
  input  logic               NN_DONE,
  input  logic [PRED_W-1:0]  PREDICTION,
  input  logic [LADDR_W-1:0] NN_ADDR,
  output logic [19:0]        SRAM_ADDR,
  output logic [IDX_W-1:0]   IMG_IDX,
  input  logic [IDX_W-1:0]   RD_IDX,
  output logic [PRED_W-1:0]  RD_PRED,
  output logic               BUSY,
  output logic               ALL_DONE
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IMAGES - 1);
  localparam logic [19:0] IMG_STEP = 20'(IMG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RUN, S_GAP, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic   s1_q, s2_q;
  logic   fired_q;
  logic   [CNT_W-1:0] cnt_q;
  logic   press;
  logic   mode_q, mode_d;
  logic   start_q, start_d;
  logic   [IDX_W-1:0] idx_q, idx_d;
  logic   [19:0] base_q, base_d;
  logic   wr_en, clr;
  logic   [PRED_W-1:0] res_q [NUM_IMAGES];

  // One press per low period, only after DEBOUNCE stable-low cycles.
  assign press = !s2_q && !fired_q && (cnt_q == CNT_LAST);

  // Synchronise the button and count how long it has been held low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      s1_q <= STEP_N;
      s2_q <= s1_q;
      if (s2_q) begin
        cnt_q   <= '0;
        fired_q <= 1'b0;
      end else if (!fired_q) begin
        if (press) fired_q <= 1'b1;
        else       cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Sequencer state and per-image bookkeeping registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      idx_q   <= '0;
      base_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  // Next-state decode; NN_START is registered so it rises after RUN entry.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    base_d  = base_q;
    start_d = 1'b0;
    wr_en   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          mode_d  = AUTO;
          idx_d   = '0;
          base_d  = BASE_ADDR;
          clr     = 1'b1;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (press || mode_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (NN_DONE) begin
          wr_en   = 1'b1;
          state_d = S_GAP;
        end else begin
          start_d = 1'b1;
        end
      end
      S_GAP: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          base_d  = base_q + IMG_STEP;
          state_d = mode_q ? S_RUN : S_ARMED;
        end
      end
      S_DONE: begin
        if (press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Results buffer: cleared when a new batch is armed, written on NN_DONE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_IMAGES; i++) res_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_IMAGES; i++) res_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_IMAGES; i++)
        if (idx_q == IDX_W'(i)) res_q[i] <= PREDICTION;
    end
  end

  // Read port; out-of-range indices return zero.
  always_comb begin
    RD_PRED = '0;
    for (int i = 0; i < NUM_IMAGES; i++)
      if (RD_IDX == IDX_W'(i)) RD_PRED = res_q[i];
  end

  assign SRAM_ADDR = base_q + 20'(NN_ADDR);
  assign NN_START  = start_q;
  assign IMG_IDX   = idx_q;
  assign BUSY      = (state_q == S_RUN) || (state_q == S_GAP);
  assign ALL_DONE  = (state_q == S_DONE);

endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Directed bench for nn_batch_sequencer: a 2-image manual instance
// and a 3-image auto instance whose base address wraps.
module tb_nn_batch_sequencer;

  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stepA = 1'b1, autoA = 1'b0, doneA = 1'b0;
  logic [3:0]  predA = '0;
  logic [15:0] addrA = '0;
  logic [1:0]  rdA = '0;
  logic        startA, busyA, allA;
  logic [19:0] srA;
  logic [1:0]  idxA;
  logic [3:0]  rpA;

  logic        stepB = 1'b1, autoB = 1'b0, doneB = 1'b0;
  logic [3:0]  predB = '0;
  logic [15:0] addrB = '0;
  logic [2:0]  rdB = '0;
  logic        startB, busyB, allB;
  logic [19:0] srB;
  logic [2:0]  idxB;
  logic [3:0]  rpB;

  int errs = 0;
  int checks = 0;

  nn_batch_sequencer #(
    .NUM_IMAGES(2), .IMG_WORDS(392), .BASE_ADDR(20'h0),
    .LADDR_W(16), .PRED_W(4), .DEBOUNCE(D)
  ) u_a (
    .CLK(clk), .RESET_N(rst_n), .STEP_N(stepA), .AUTO(autoA),
    .NN_START(startA), .NN_DONE(doneA), .PREDICTION(predA),
    .NN_ADDR(addrA), .SRAM_ADDR(srA), .IMG_IDX(idxA),
    .RD_IDX(rdA), .RD_PRED(rpA), .BUSY(busyA), .ALL_DONE(allA)
  );

  nn_batch_sequencer #(
    .NUM_IMAGES(3), .IMG_WORDS(392), .BASE_ADDR(20'hFFF00),
    .LADDR_W(16), .PRED_W(4), .DEBOUNCE(D)
  ) u_b (
    .CLK(clk), .RESET_N(rst_n), .STEP_N(stepB), .AUTO(autoB),
    .NN_START(startB), .NN_DONE(doneB), .PREDICTION(predB),
    .NN_ADDR(addrB), .SRAM_ADDR(srB), .IMG_IDX(idxB),
    .RD_IDX(rdB), .RD_PRED(rpB), .BUSY(busyB), .ALL_DONE(allB)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the button low for n cycles, then release for 6.
  task automatic step(input bit b, input int n);
    if (b) stepB = 1'b0; else stepA = 1'b0;
    cyc(n);
    if (b) stepB = 1'b1; else stepA = 1'b1;
    cyc(6);
  endtask

  task automatic wait_start(input bit b);
    int n = 0;
    while (((b ? startB : startA) !== 1'b1) && n < 200) begin
      cyc(1);
      n++;
    end
    chk(b ? "b_start" : "a_start", b ? startB : startA, 1);
  endtask

  logic [19:0] expB [3];
  logic [3:0]  prB [3];

  initial begin
    expB[0] = 20'hFFF00; expB[1] = 20'h00088; expB[2] = 20'h00210;
    prB[0] = 4'd1; prB[1] = 4'd2; prB[2] = 4'd9;

    cyc(3);
    chk("rst_startA", startA, 0);
    chk("rst_idxA", idxA, 0);
    chk("rst_allA", allA, 0);
    chk("rst_busyA", busyA, 0);
    chk("rst_rdA", rpA, 0);
    chk("rst_srB", srB, 20'hFFF00);
    rst_n = 1'b1;
    cyc(2);

    // Debounce: a long hold is one press (IDLE->ARMED only).
    step(0, 1000);
    cyc(3);
    chk("t4_long_one", busyA, 0);
    step(0, D - 1);
    cyc(3);
    chk("t4_short_none", busyA, 0);
    step(0, D);
    chk("t4_exact_press", busyA, 1);

    // Manual image 0.
    wait_start(0);
    addrA = 16'd5;
    #1;
    chk("t2_sr0", srA, 20'd5);
    chk("t2_idx0", idxA, 0);

    // Presses and AUTO changes in RUN are ignored.
    autoA = 1'b1;
    step(0, D + 4);
    chk("t5_run_start", startA, 1);
    chk("t5_run_idx", idxA, 0);

    doneA = 1'b1; predA = 4'd7;
    cyc(1);
    doneA = 1'b0; predA = 4'd0;
    chk("t2_gap_start", startA, 0);
    chk("t2_gap_busy", busyA, 1);
    cyc(1);
    chk("t2_armed_busy", busyA, 0);
    chk("t2_armed_idx", idxA, 1);
    chk("t2_armed_start", startA, 0);

    // NN_DONE while ARMED must not write results.
    doneA = 1'b1; predA = 4'd15;
    cyc(2);
    doneA = 1'b0; predA = 4'd0;
    rdA = 2'd0; #1;
    chk("t5_res0", rpA, 7);
    rdA = 2'd1; #1;
    chk("t5_res1", rpA, 0);
    chk("t5_still_armed", busyA, 0);

    // Manual image 1.
    step(0, D + 4);
    wait_start(0);
    addrA = 16'd10;
    #1;
    chk("t2_sr1", srA, 20'd402);
    doneA = 1'b1; predA = 4'd3;
    cyc(1);
    doneA = 1'b0; predA = 4'd0;
    chk("t2_gap1_start", startA, 0);
    cyc(1);
    chk("t2_all_done", allA, 1);
    chk("t2_busy_done", busyA, 0);
    rdA = 2'd0; #1;
    chk("t2_rd0", rpA, 7);
    rdA = 2'd1; #1;
    chk("t2_rd1", rpA, 3);
    rdA = 2'd2; #1;
    chk("t2_rd_oob", rpA, 0);

    // Auto batch on the wrapping instance.
    autoB = 1'b1;
    step(1, D + 4);
    for (int i = 0; i < 3; i++) begin
      wait_start(1);
      addrB = 16'd0;
      #1;
      chk("t3_sram", srB, expB[i]);
      chk("t3_idx", idxB, i);
      cyc(40);
      doneB = 1'b1; predB = prB[i];
      cyc(1);
      doneB = 1'b0; predB = 4'd0;
      chk("t3_gap_low", startB, 0);
    end
    cyc(1);
    chk("t3_all_done", allB, 1);
    for (int i = 0; i < 3; i++) begin
      rdB = 3'(i); #1;
      chk("t3_rd", rpB, prB[i]);
    end
    rdB = 3'd3; #1;
    chk("t6_rd_oob", rpB, 0);

    // DONE -> IDLE keeps results; arming clears them.
    step(1, D + 4);
    rdB = 3'd0; #1;
    chk("t3_idle_alldone", allB, 0);
    chk("t3_retained", rpB, 1);
    step(1, D + 4);
    chk("t3_cleared", rpB, 0);
    wait_start(1);
    cyc(5);
    doneB = 1'b1; predB = 4'd5;
    cyc(1);
    doneB = 1'b0; predB = 4'd0;
    chk("t1_pre_res", rpB, 5);
    wait_start(1);
    chk("t1_pre_idx", idxB, 1);

    // Asynchronous reset mid-RUN.
    rst_n = 1'b0;
    #1;
    chk("t1_start", startB, 0);
    chk("t1_idx", idxB, 0);
    chk("t1_all", allB, 0);
    chk("t1_busy", busyB, 0);
    chk("t1_res", rpB, 0);
    chk("t1_allA", allA, 0);
    rdA = 2'd0; #1;
    chk("t1_resA0", rpA, 0);
    rdA = 2'd1; #1;
    chk("t1_resA1", rpA, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
